// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: owns the rotating priority pointer and holds one grant at a time.
// Optional hold watchdog is compiled in with `define RR_GRANT_WATCHDOG_EN.
module rr_grant_ctrl #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic [N-1:0]         prio,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  generate
    if (N < 2 || TIMEOUT < 2) begin : g_bad_param
      $error("rr_grant_ctrl: N and TIMEOUT must both be at least 2");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic [IW-1:0] gnt_id_reg, gnt_id_next;
  logic          busy_reg, busy_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [N-1:0]  prio_reg, prio_dec;
  logic          timeout_reg, timeout_next;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   scan_idx;
  logic [N-1:0]  win_onehot;
  logic [IW-1:0] ptr_adv;
  logic          owner_req;
  logic          expire;
  logic          release_now;

  // Circular scan starting at the pointer position; first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_reg} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(N))
        scan_idx = scan_idx - (IW+1)'(N);
      if (!win_found && req[scan_idx[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IW-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_decode
      assign win_onehot[gi] = (win_idx == IW'(gi));
      assign prio_dec[gi]   = (ptr_next == IW'(gi));
    end
  endgenerate

  assign owner_req = req[gnt_id_reg];
  assign ptr_adv   = (gnt_id_reg == IW'(N-1)) ? '0 : gnt_id_reg + 1'b1;

`ifdef RR_GRANT_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] hold_cnt_reg;

  // Counter sits at zero in IDLE, so it starts from zero on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_cnt_reg <= '0;
    else if (state_reg == IDLE)
      hold_cnt_reg <= '0;
    else
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
  end

  assign expire = (state_reg == BUSY) && (hold_cnt_reg == CW'(TIMEOUT-1));
`else
  assign expire = 1'b0;
`endif

  assign release_now = done || !owner_req || expire;

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    busy_next    = busy_reg;
    ptr_next     = ptr_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next  = BUSY;
          gnt_next    = win_onehot;
          gnt_id_next = win_idx;
          busy_next   = 1'b1;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_next   = IDLE;
          gnt_next     = '0;
          gnt_id_next  = '0;
          busy_next    = 1'b0;
          ptr_next     = ptr_adv;
          // Only a release forced purely by the watchdog is flagged.
          timeout_next = expire && !done && owner_req;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      busy_reg    <= 1'b0;
      ptr_reg     <= '0;
      prio_reg    <= N'(1);
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      busy_reg    <= busy_next;
      ptr_reg     <= ptr_next;
      prio_reg    <= prio_dec;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign busy    = busy_reg;
  assign prio    = prio_reg;
  assign timeout = timeout_reg;

endmodule
